huff_tree_ctrl: RTL and testbench
=================================

# huff_tree_ctrl

Sequencer that builds the Huffman tree for the six-symbol coder by repeatedly merging the two lightest active nodes. It drives the root-node memory's write port, issuing one root record per merge into roots 6..10. It then reports the final root weight. It sits between the symbol-count stage, which supplies six leaf weights, and the code-walk stage, which reads the finished tree.

## Interface
- W, 8, weight width in bits; leaf and root weights.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  one-cycle request; sampled only in IDLE.
- cnt0..cnt5  in  W each  leaf weights for nodes 0..5; captured on the accepted start edge.
- tm_clear  out  1  clear strobe to root memory.
- tm_w_r  out  1  root memory write enable (1 = write).
- tm_root_sel  out  4  root index written (6..10).
- tm_node_l  out  4  left child index.
- tm_node_r  out  4  right child index.
- busy  out  1  high from the accepted start until DONE is exited.
- done  out  1  one-cycle completion pulse.
- root_weight  out  W  weight of root 10; valid from done onward, held until the next start.

## Operation
- Node space: 0..5 leaves, 6..10 roots, 11 = empty. Each node has a weight register and an active bit.
- States:
  - IDLE: start=1 captures cnt0..5 into nodes 0..5 as active, clears roots to inactive, sets k=0, and goes to CLEAR.
  - CLEAR: tm_clear=1 for exactly one cycle, then SCAN.
  - SCAN: visits index 0..10, one per cycle, for 11 cycles. Inactive indices are skipped.
  - MERGE: one cycle. Writes root 6+k with left=m1 and right=m2. Deactivates m1 and m2, activates node 6+k with weight w1+w2. If k=4, goes to DONE; otherwise k++ and goes to SCAN.
  - DONE: done=1 for one cycle, then IDLE.
- Min-2 tracking during SCAN: w1 and w2 start at all-ones with m1=m2=11. For each active index i with weight w:
  - if w<w1, then (m2,w2)←(m1,w1) and (m1,w1)←(i,w);
  - else if w<w2, then (m2,w2)←(i,w).
- Comparisons are strict, so the lower index wins on equal weight, and w1≤w2 always.
- Sum arithmetic: W+1-bit add. If bit W is set, the result saturates to all-ones.
- Zero weights are legal and treated as ordinary active nodes.
- start while busy is ignored.
- Async reset mid-build returns to IDLE with all outputs at reset values. Root memory contents are then stale, and the next start's CLEAR fixes them.

## Timing
- Reset values:
  - tm_clear=0, tm_w_r=0, busy=0, done=0, root_weight=0;
  - tm_root_sel=0;
  - tm_node_l=tm_node_r=11.
- All outputs are registered on the rising edge. The root memory samples on the falling edge, so outputs are stable for a half cycle before sampling.
- Cycle numbering: start accepted at edge 0, then:
  - CLEAR occupies cycle 1.
  - Merge k has SCAN in cycles 2+12k..12+12k and MERGE in cycle 13+12k.
  - DONE is cycle 62; done is high in cycle 62 only.
- tm_w_r is high only in MERGE cycles, 5 pulses per build.
- tm_root_sel, tm_node_l and tm_node_r are valid whenever tm_w_r=1. Otherwise they hold their last values.
- busy rises in cycle 1 and falls after cycle 62. start is accepted again from cycle 63.

## Structure
- Shared package huff_pkg:
  - NODE_EMPTY=11, ROOT_BASE=6, N_LEAF=6, N_ROOT=5, N_NODE=11;
  - state enum {IDLE, CLEAR, SCAN, MERGE, DONE};
  - node index type, 4 bits.
- Sub-module huff_min2_scan holds the (m1,w1,m2,w2) registers. It takes init, a valid strobe, the index and the weight, and applies the tracking rule above. The top module holds the FSM, the weight/active arrays and the output registers.

## Test plan
- Weights {10,20,30,5,15,20}: writes must be
  - (6: l=3, r=0)
  - (7: l=4, r=6)
  - (8: l=1, r=5)
  - (9: l=2, r=7)
  - (10: l=8, r=9)
  - root_weight=100; done in cycle 62.
- All weights 7: lower-index tie rule gives (6:0,1), (7:2,3), (8:4,5), (9:6,7), (10:8,9); root_weight=42.
- Weights {255,255,1,1,1,1}: the final sum saturates, root_weight=255; no wrap in any intermediate root.
- start pulsed again in cycles 5 and 40: ignored; write sequence and done timing are unchanged.
- reset asserted low in cycle 30: all outputs return to reset values asynchronously. A new start then gives tm_clear in cycle 1 and a correct full build.
- Weights {0,0,0,0,0,9}: (6:0,1), (7:2,3), (8:4,6), (9:7,8), (10:9,5); root_weight=9.

Source files
------------

// File: rtl/huff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : huff_pkg
// Description : Shared constants and types for the six-symbol Huffman tree
//               builder: node-space layout, node index type and the
//               sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package huff_pkg;

  localparam int NODE_EMPTY = 11;  // "no node" marker for child/min slots
  localparam int ROOT_BASE  = 6;   // first internal (root) node index
  localparam int N_LEAF     = 6;
  localparam int N_ROOT     = 5;
  localparam int N_NODE     = 11;

  typedef logic [3:0] node_idx_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SCAN  = 3'd2,
    MERGE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage : huff_pkg
`default_nettype wire

// File: rtl/huff_min2_scan.sv
`default_nettype none
// ============================================================================
// Module      : huff_min2_scan
// Description : Running two-smallest tracker. Fed one (index, weight) pair per
//               cycle in ascending index order, it keeps the lightest node in
//               (m1,w1) and the second lightest in (m2,w2). Strict compares
//               make the lower index win on equal weight.
// Ports       : clk, reset (async active-low)
//               init          - reload empty slots (m=11, w=all-ones)
//               valid         - idx/weight present an active node this cycle
//               idx, weight   - candidate node
//               m1,w1,m2,w2   - registered result
//               m1_nxt,m2_nxt - indices including this cycle's candidate
// Revision    : 1.0 - initial release
// ============================================================================
module huff_min2_scan
  import huff_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         valid,
  input  node_idx_t    idx,
  input  logic [W-1:0] weight,
  output node_idx_t    m1,
  output logic [W-1:0] w1,
  output node_idx_t    m2,
  output logic [W-1:0] w2,
  output node_idx_t    m1_nxt,
  output node_idx_t    m2_nxt
);

  localparam node_idx_t EMPTY_IDX = node_idx_t'(NODE_EMPTY);

  logic [W-1:0] w1_nxt;
  logic [W-1:0] w2_nxt;

  // An empty slot accepts any candidate, so a node whose weight equals the
  // all-ones seed value is still picked up instead of being lost.
  always_comb begin
    m1_nxt = m1;
    w1_nxt = w1;
    m2_nxt = m2;
    w2_nxt = w2;
    if (init) begin
      m1_nxt = EMPTY_IDX;
      w1_nxt = '1;
      m2_nxt = EMPTY_IDX;
      w2_nxt = '1;
    end else if (valid) begin
      if ((m1 == EMPTY_IDX) || (weight < w1)) begin
        m2_nxt = m1;
        w2_nxt = w1;
        m1_nxt = idx;
        w1_nxt = weight;
      end else if ((m2 == EMPTY_IDX) || (weight < w2)) begin
        m2_nxt = idx;
        w2_nxt = weight;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m1 <= EMPTY_IDX;
      w1 <= '1;
      m2 <= EMPTY_IDX;
      w2 <= '1;
    end else begin
      m1 <= m1_nxt;
      w1 <= w1_nxt;
      m2 <= m2_nxt;
      w2 <= w2_nxt;
    end
  end

endmodule : huff_min2_scan
`default_nettype wire

// File: rtl/huff_tree_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : huff_tree_ctrl
// Description : Builds the six-leaf Huffman tree by five merges of the two
//               lightest active nodes, writing one root record per merge
//               (roots 6..10) to the root-node memory, then reports the
//               weight of root 10.
// Ports       : clk, reset (async active-low)
//               start        - build request, honoured only in IDLE
//               cnt0..cnt5   - leaf weights, captured on accepted start
//               tm_clear     - one-cycle root memory clear strobe
//               tm_w_r       - root memory write enable
//               tm_root_sel  - root index written
//               tm_node_l/r  - left/right child index
//               busy, done   - build in progress / completion pulse
//               root_weight  - final root weight, held until next done
// Revision    : 1.0 - initial release
// ============================================================================
module huff_tree_ctrl
  import huff_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] cnt0,
  input  logic [W-1:0] cnt1,
  input  logic [W-1:0] cnt2,
  input  logic [W-1:0] cnt3,
  input  logic [W-1:0] cnt4,
  input  logic [W-1:0] cnt5,
  output logic         tm_clear,
  output logic         tm_w_r,
  output node_idx_t    tm_root_sel,
  output node_idx_t    tm_node_l,
  output node_idx_t    tm_node_r,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] root_weight
);

  localparam node_idx_t         EMPTY_IDX   = node_idx_t'(NODE_EMPTY);
  localparam node_idx_t         LAST_IDX    = node_idx_t'(N_NODE - 1);
  localparam logic [2:0]        LAST_MERGE  = 3'(N_ROOT - 1);
  localparam logic [N_NODE-1:0] LEAVES_ONLY = N_NODE'((1 << N_LEAF) - 1);

  state_t             state;
  logic [W-1:0]       weight [N_NODE];
  logic [N_NODE-1:0]  active;
  node_idx_t          scan_idx;
  logic [2:0]         k;

  node_idx_t          m1, m2, m1_nxt, m2_nxt;
  logic [W-1:0]       w1, w2;
  logic               scan_init;
  logic               scan_valid;
  node_idx_t          root_idx;
  logic [W:0]         sum_full;
  logic [W-1:0]       merged;

  // Tracker is reseeded in the cycle before every scan pass.
  assign scan_init  = (state == CLEAR) || (state == MERGE);
  assign scan_valid = (state == SCAN) && active[scan_idx];
  assign root_idx   = node_idx_t'(ROOT_BASE) + {1'b0, k};

  assign sum_full = {1'b0, w1} + {1'b0, w2};
  assign merged   = sum_full[W] ? '1 : sum_full[W-1:0];

  huff_min2_scan #(.W(W)) u_scan (
    .clk    (clk),
    .reset  (reset),
    .init   (scan_init),
    .valid  (scan_valid),
    .idx    (scan_idx),
    .weight (weight[scan_idx]),
    .m1     (m1),
    .w1     (w1),
    .m2     (m2),
    .w2     (w2),
    .m1_nxt (m1_nxt),
    .m2_nxt (m2_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      active      <= '0;
      scan_idx    <= '0;
      k           <= '0;
      tm_clear    <= 1'b0;
      tm_w_r      <= 1'b0;
      tm_root_sel <= '0;
      tm_node_l   <= EMPTY_IDX;
      tm_node_r   <= EMPTY_IDX;
      busy        <= 1'b0;
      done        <= 1'b0;
      root_weight <= '0;
      for (int i = 0; i < N_NODE; i++) begin
        weight[i] <= '0;
      end
    end else begin
      tm_clear <= 1'b0;
      tm_w_r   <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            weight[0] <= cnt0;
            weight[1] <= cnt1;
            weight[2] <= cnt2;
            weight[3] <= cnt3;
            weight[4] <= cnt4;
            weight[5] <= cnt5;
            active    <= LEAVES_ONLY;
            k         <= '0;
            tm_clear  <= 1'b1;
            busy      <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          scan_idx <= '0;
          state    <= SCAN;
        end
        SCAN: begin
          if (scan_idx == LAST_IDX) begin
            // The write record must be on the port during MERGE itself, so
            // the children are taken from the tracker's next-state view,
            // which already includes the final index of the pass.
            tm_w_r      <= 1'b1;
            tm_root_sel <= root_idx;
            tm_node_l   <= m1_nxt;
            tm_node_r   <= m2_nxt;
            state       <= MERGE;
          end else begin
            scan_idx <= scan_idx + 4'd1;
          end
        end
        MERGE: begin
          active[m1]       <= 1'b0;
          active[m2]       <= 1'b0;
          active[root_idx] <= 1'b1;
          weight[root_idx] <= merged;
          scan_idx         <= '0;
          if (k == LAST_MERGE) begin
            root_weight <= merged;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            k     <= k + 3'd1;
            state <= SCAN;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : huff_tree_ctrl
`default_nettype wire

// File: tb/tb_huff_tree_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_huff_tree_ctrl
// Description : Self-checking bench for huff_tree_ctrl. A reference model
//               picks the two lightest active nodes (lower index on ties) by
//               plain search over arrays; builds are recorded cycle by cycle
//               and compared against the model and the fixed build timeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_huff_tree_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] cnt0 = '0, cnt1 = '0, cnt2 = '0, cnt3 = '0, cnt4 = '0, cnt5 = '0;
  logic         tm_clear, tm_w_r, busy, done;
  logic [3:0]   tm_root_sel, tm_node_l, tm_node_r;
  logic [W-1:0] root_weight;

  int checks = 0;
  int failures = 0;

  // Per-build observation record
  int n_wr;
  int wr_cyc [8];
  int wr_sel [8];
  int wr_l [8];
  int wr_r [8];
  int clear_first, clear_count, done_first, done_count;
  int busy_first, busy_last, hold_bad, root_seen, root_end;

  // Model expectations
  int exp_sel [5];
  int exp_l [5];
  int exp_r [5];
  int exp_root;

  huff_tree_ctrl #(.W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cnt0        (cnt0),
    .cnt1        (cnt1),
    .cnt2        (cnt2),
    .cnt3        (cnt3),
    .cnt4        (cnt4),
    .cnt5        (cnt5),
    .tm_clear    (tm_clear),
    .tm_w_r      (tm_w_r),
    .tm_root_sel (tm_root_sel),
    .tm_node_l   (tm_node_l),
    .tm_node_r   (tm_node_r),
    .busy        (busy),
    .done        (done),
    .root_weight (root_weight)
  );

  always #5 clk = ~clk;

  // Reference: repeatedly take the lightest and second-lightest active
  // nodes (ties to lower index), saturating the sum at 255.
  task automatic model(input int w [6]);
    int wt [11];
    bit act [11];
    int a, b, s;
    for (int i = 0; i < 11; i++) begin
      wt[i]  = (i < 6) ? w[i] : 0;
      act[i] = (i < 6);
    end
    for (int m = 0; m < 5; m++) begin
      a = -1;
      b = -1;
      for (int i = 0; i < 11; i++)
        if (act[i] && (a < 0 || wt[i] < wt[a])) a = i;
      for (int i = 0; i < 11; i++)
        if (act[i] && i != a && (b < 0 || wt[i] < wt[b])) b = i;
      exp_sel[m] = 6 + m;
      exp_l[m]   = a;
      exp_r[m]   = b;
      act[a]     = 1'b0;
      act[b]     = 1'b0;
      s          = wt[a] + wt[b];
      wt[6 + m]  = (s > 255) ? 255 : s;
      act[6 + m] = 1'b1;
    end
    exp_root = wt[10];
  endtask

  // Starts a build (start high into edge 0) and records 64 cycles.
  // re1/re2 name cycles in which start is pulsed again.
  task automatic run_build(input int w [6], input int re1, input int re2);
    logic [11:0] prev;
    prev = '0;
    n_wr = 0;
    clear_first = -1; clear_count = 0; done_first = -1; done_count = 0;
    busy_first = -1; busy_last = -1; hold_bad = 0; root_seen = -1; root_end = -1;
    for (int i = 0; i < 8; i++) begin
      wr_cyc[i] = -1; wr_sel[i] = -1; wr_l[i] = -1; wr_r[i] = -1;
    end
    @(negedge clk);
    cnt0 = W'(w[0]); cnt1 = W'(w[1]); cnt2 = W'(w[2]);
    cnt3 = W'(w[3]); cnt4 = W'(w[4]); cnt5 = W'(w[5]);
    start = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (tm_clear) begin
        clear_count++;
        if (clear_first < 0) clear_first = c;
      end
      if (tm_w_r) begin
        if (n_wr < 8) begin
          wr_cyc[n_wr] = c;
          wr_sel[n_wr] = int'(tm_root_sel);
          wr_l[n_wr]   = int'(tm_node_l);
          wr_r[n_wr]   = int'(tm_node_r);
        end
        n_wr++;
      end else if (c > 1 && {tm_root_sel, tm_node_l, tm_node_r} !== prev) begin
        hold_bad++;
      end
      prev = {tm_root_sel, tm_node_l, tm_node_r};
      if (done) begin
        done_count++;
        if (done_first < 0) begin
          done_first = c;
          root_seen  = int'(root_weight);
        end
      end
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (c == 64) root_end = int'(root_weight);
      if (c == re1 || c == re2) start = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tm_clear, tm_w_r, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes: got clear/wr/busy/done=%b expected 0000",
               {tm_clear, tm_w_r, busy, done});
    end
    checks++;
    if (tm_root_sel !== 4'd0 || tm_node_l !== 4'd11 || tm_node_r !== 4'd11) begin
      failures++;
      $display("FAIL reset_port: got sel=%0d l=%0d r=%0d expected sel=0 l=11 r=11",
               tm_root_sel, tm_node_l, tm_node_r);
    end
    checks++;
    if (root_weight !== '0) begin
      failures++;
      $display("FAIL reset_root: got %0d expected 0", root_weight);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_builds();
    int sets [4][6] = '{'{10, 20, 30, 5, 15, 20}, '{7, 7, 7, 7, 7, 7},
                        '{255, 255, 1, 1, 1, 1}, '{0, 0, 0, 0, 0, 9}};
    int w [6];
    for (int s = 0; s < 12; s++) begin
      for (int i = 0; i < 6; i++) begin
        if (s < 4)       w[i] = sets[s][i];
        else if (s < 8)  w[i] = int'($urandom_range(0, 3));
        else             w[i] = int'($urandom_range(0, 255));
      end
      model(w);
      run_build(w, -1, -1);
      for (int m = 0; m < 5; m++) begin
        checks++;
        if (wr_cyc[m] !== 13 + 12 * m || wr_sel[m] !== exp_sel[m] ||
            wr_l[m] !== exp_l[m] || wr_r[m] !== exp_r[m]) begin
          failures++;
          $display("FAIL build%0d_write%0d: got cyc=%0d root=%0d l=%0d r=%0d expected cyc=%0d root=%0d l=%0d r=%0d",
                   s, m, wr_cyc[m], wr_sel[m], wr_l[m], wr_r[m],
                   13 + 12 * m, exp_sel[m], exp_l[m], exp_r[m]);
        end
      end
      checks++;
      if (n_wr !== 5 || hold_bad !== 0) begin
        failures++;
        $display("FAIL build%0d_wr_count: got writes=%0d hold_errs=%0d expected 5 and 0",
                 s, n_wr, hold_bad);
      end
      checks++;
      if (done_first !== 62 || done_count !== 1 || root_seen !== exp_root) begin
        failures++;
        $display("FAIL build%0d_done: got cyc=%0d pulses=%0d root=%0d expected cyc=62 pulses=1 root=%0d",
                 s, done_first, done_count, root_seen, exp_root);
      end
      checks++;
      if (clear_first !== 1 || clear_count !== 1 || busy_first !== 1 ||
          busy_last !== 62 || root_end !== exp_root) begin
        failures++;
        $display("FAIL build%0d_frame: got clear@%0d x%0d busy %0d..%0d root_hold=%0d expected clear@1 x1 busy 1..62 root_hold=%0d",
                 s, clear_first, clear_count, busy_first, busy_last, root_end, exp_root);
      end
    end
  endtask

  task automatic test_restart_ignored();
    int w [6] = '{10, 20, 30, 5, 15, 20};
    model(w);
    run_build(w, 5, 40);
    for (int m = 0; m < 5; m++) begin
      checks++;
      if (wr_cyc[m] !== 13 + 12 * m || wr_sel[m] !== exp_sel[m] ||
          wr_l[m] !== exp_l[m] || wr_r[m] !== exp_r[m]) begin
        failures++;
        $display("FAIL restart_write%0d: got cyc=%0d root=%0d l=%0d r=%0d expected cyc=%0d root=%0d l=%0d r=%0d",
                 m, wr_cyc[m], wr_sel[m], wr_l[m], wr_r[m],
                 13 + 12 * m, exp_sel[m], exp_l[m], exp_r[m]);
      end
    end
    checks++;
    if (n_wr !== 5 || clear_count !== 1 || done_first !== 62 || done_count !== 1 ||
        root_seen !== 100) begin
      failures++;
      $display("FAIL restart_frame: got writes=%0d clears=%0d done@%0d x%0d root=%0d expected 5 1 62 1 100",
               n_wr, clear_count, done_first, done_count, root_seen);
    end
  endtask

  task automatic test_reset_midbuild();
    int w [6] = '{7, 7, 7, 7, 7, 7};
    @(negedge clk);
    cnt0 = 8'd10; cnt1 = 8'd20; cnt2 = 8'd30; cnt3 = 8'd5; cnt4 = 8'd15; cnt5 = 8'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);   // now in cycle 30
    checks++;
    if (busy !== 1'b1 || tm_root_sel !== 4'd7) begin
      failures++;
      $display("FAIL midbuild_pre: got busy=%b sel=%0d expected busy=1 sel=7", busy, tm_root_sel);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({tm_clear, tm_w_r, busy, done} !== 4'b0000 || tm_root_sel !== 4'd0 ||
        tm_node_l !== 4'd11 || tm_node_r !== 4'd11 || root_weight !== '0) begin
      failures++;
      $display("FAIL midbuild_reset: got c/w/b/d=%b sel=%0d l=%0d r=%0d root=%0d expected 0000 0 11 11 0",
               {tm_clear, tm_w_r, busy, done}, tm_root_sel, tm_node_l, tm_node_r, root_weight);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model(w);
    run_build(w, -1, -1);
    for (int m = 0; m < 5; m++) begin
      checks++;
      if (wr_cyc[m] !== 13 + 12 * m || wr_sel[m] !== exp_sel[m] ||
          wr_l[m] !== exp_l[m] || wr_r[m] !== exp_r[m]) begin
        failures++;
        $display("FAIL post_reset_write%0d: got cyc=%0d root=%0d l=%0d r=%0d expected cyc=%0d root=%0d l=%0d r=%0d",
                 m, wr_cyc[m], wr_sel[m], wr_l[m], wr_r[m],
                 13 + 12 * m, exp_sel[m], exp_l[m], exp_r[m]);
      end
    end
    checks++;
    if (clear_first !== 1 || clear_count !== 1 || done_first !== 62 || root_seen !== 42) begin
      failures++;
      $display("FAIL post_reset_frame: got clear@%0d x%0d done@%0d root=%0d expected 1 1 62 42",
               clear_first, clear_count, done_first, root_seen);
    end
  endtask

  initial begin
    test_reset();
    test_builds();
    test_restart_ignored();
    test_reset_midbuild();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_huff_tree_ctrl
`default_nettype wire
